// File: rtl/data_receiver.sv
// Deserialiser for the data_transmitter serial link: resynchronises the three
// link lines, rebuilds 64-bit words from 8 LSB-first bytes and flags malformed frames.
module data_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_transmission,
    input  logic        line_clock,
    input  logic        line_data,
    output logic [63:0] data,
    output logic        valid,
    output logic        busy,
    output logic        frame_error
);

    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BYTE, GAP} state_t;

    logic [SYNC_STAGES-1:0] tr_sync_q, ck_sync_q, dt_sync_q;
    logic                   tr_dly_q, ck_dly_q;
    logic                   tr_s, ck_s, dt_s;
    logic                   tr_rise, tr_fall, ck_rise, sample;

    state_t         state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [63:0]    slot_q, slot_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [63:0]    data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            tr_sync_q <= '0;
            ck_sync_q <= '0;
            dt_sync_q <= '0;
            tr_dly_q  <= 1'b0;
            ck_dly_q  <= 1'b0;
        end else begin
            tr_sync_q <= {tr_sync_q[SYNC_STAGES-2:0], line_transmission};
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], line_clock};
            dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], line_data};
            tr_dly_q  <= tr_s;
            ck_dly_q  <= ck_s;
        end
    end

    assign tr_s    = tr_sync_q[SYNC_STAGES-1];
    assign ck_s    = ck_sync_q[SYNC_STAGES-1];
    assign dt_s    = dt_sync_q[SYNC_STAGES-1];
    assign tr_rise = tr_s & ~tr_dly_q;
    assign tr_fall = ~tr_s & tr_dly_q;
    assign ck_rise = ck_s & ~ck_dly_q;
    // A clock edge coinciding with the framing fall is dropped: tr_s is already low.
    assign sample  = ck_rise & tr_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            slot_q    <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            slot_q    <= slot_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        slot_d    = slot_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tr_rise) begin
                    state_d   = BYTE;
                    idx_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            BYTE: begin
                if (sample) begin
                    if (bit_cnt_q == 4'd8) begin
                        abort = 1'b1;
                    end else begin
                        shift_d   = {dt_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            slot_d[{idx_q, 3'b000} +: 8] = shift_d;
                        end
                    end
                end else if (tr_fall) begin
                    if (bit_cnt_q != 4'd8) begin
                        abort = 1'b1;
                    end else if (idx_q != 3'd7) begin
                        idx_d     = idx_q + 3'd1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        state_d = IDLE;
                        data_d  = slot_q;
                        valid_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // Timeout wins over a simultaneous framing edge.
                if (gap_cnt_q == GAP_LAST) begin
                    abort = 1'b1;
                end else if (tr_rise) begin
                    state_d   = BYTE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = IDLE;
            ferr_d    = 1'b1;
            bit_cnt_d = '0;
            idx_d     = '0;
            shift_d   = '0;
            slot_d    = '0;
            gap_cnt_d = '0;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_data_receiver.sv
// Directed self-checking bench for data_receiver: drives the serial link lines
// slowly relative to clk and checks words, pulses and error timing.
module tb_data_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int GAP_TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_transmission = 1'b0;
    logic        line_clock = 1'b0;
    logic        line_data = 1'b0;
    logic [63:0] data;
    logic        valid, busy, frame_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int ferr_cyc  = 0;
    int fall_cyc  = 0;
    int rise_cyc  = 0;
    logic [63:0] vq[$];

    data_receiver #(.SYNC_STAGES(SYNC_STAGES), .GAP_TIMEOUT(GAP_TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .line_transmission (line_transmission),
        .line_clock        (line_clock),
        .line_data         (line_data),
        .data              (data),
        .valid             (valid),
        .busy              (busy),
        .frame_error       (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            vq.push_back(data);
        end
        if (frame_error === 1'b1) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tr_up();
        line_transmission = 1'b1;
        wait_cyc(3);
    endtask

    task automatic tr_down();
        wait_cyc(2);
        line_transmission = 1'b0;
        fall_cyc = cyc;
        wait_cyc(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            line_data = (i < 8) ? b[i] : 1'b0;
            wait_cyc(2);
            line_clock = 1'b1;
            rise_cyc = cyc;
            wait_cyc(3);
            line_clock = 1'b0;
            wait_cyc(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tr_up();
        send_bits(b, 8);
        tr_down();
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8]);
        wait_cyc(5);
        $display("word sent %h: data=%h valid_cnt=%0d ferr_cnt=%0d", w, data, valid_cnt, ferr_cnt);
    endtask

    int v0, f0;

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        check_eq("reset_data", data, 64'h0);
        check_eq("reset_valid", {63'h0, valid}, 64'h0);
        check_eq("reset_busy", {63'h0, busy}, 64'h0);
        check_eq("reset_ferr", {63'h0, frame_error}, 64'h0);
        wait_cyc(2);

        // Clean word
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hEF);
        check_eq("busy_midword", {63'h0, busy}, 64'h1);
        for (int k = 1; k < 8; k++) send_byte(8'(64'h0123_4567_89AB_CDEF >> (8*k)));
        wait_cyc(5);
        $display("word sent 0123456789abcdef: data=%h", data);
        check_eq("clean_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check_eq("clean_data", data, 64'h0123_4567_89AB_CDEF);
        check_eq("clean_vq", vq[vq.size()-1], 64'h0123_4567_89AB_CDEF);
        check_eq("clean_busy", {63'h0, busy}, 64'h0);
        check_eq("clean_ferr", 64'(ferr_cnt - f0), 64'd0);

        // Back-to-back words
        v0 = valid_cnt;
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        send_word(64'h0);
        check_eq("b2b_valid_cnt", 64'(valid_cnt - v0), 64'd2);
        check_eq("b2b_first", vq[vq.size()-2], 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("b2b_second", vq[vq.size()-1], 64'h0);
        check_eq("b2b_data", data, 64'h0);

        // Short byte 3
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int k = 0; k < 3; k++) send_byte(8'h11);
        tr_up();
        send_bits(8'h11, 5);
        tr_down();
        wait_cyc(5);
        $display("short byte sent: data=%h ferr_cnt=%0d", data, ferr_cnt);
        check_eq("short_ferr", 64'(ferr_cnt - f0), 64'd1);
        check_eq("short_valid", 64'(valid_cnt - v0), 64'd0);
        check_eq("short_data", data, 64'h0);
        check_eq("short_busy", {63'h0, busy}, 64'h0);
        send_word(64'hA5);
        check_eq("after_short_data", data, 64'hA5);
        check_eq("after_short_valid", 64'(valid_cnt - v0), 64'd1);

        // Gap timeout after byte 2
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int k = 0; k < 3; k++) send_byte(8'h3C);
        check_eq("gap_busy", {63'h0, busy}, 64'h1);
        wait_cyc(GAP_TIMEOUT + 10);
        $display("gap idle done: ferr_cnt=%0d busy=%b", ferr_cnt, busy);
        check_eq("gap_ferr", 64'(ferr_cnt - f0), 64'd1);
        check_eq("gap_timing", 64'(ferr_cyc - fall_cyc), 64'(GAP_TIMEOUT + SYNC_STAGES + 1));
        check_eq("gap_busy_after", {63'h0, busy}, 64'h0);
        check_eq("gap_valid", 64'(valid_cnt - v0), 64'd0);
        check_eq("gap_data", data, 64'hA5);

        // Overlong byte: 9 edges in one window
        v0 = valid_cnt; f0 = ferr_cnt;
        tr_up();
        send_bits(8'hFF, 9);
        check_eq("long_ferr_before_fall", 64'(ferr_cnt - f0), 64'd1);
        check_eq("long_timing", 64'(ferr_cyc - rise_cyc), 64'(SYNC_STAGES + 1));
        tr_down();
        wait_cyc(5);
        $display("overlong byte sent: ferr_cnt=%0d", ferr_cnt);
        check_eq("long_ferr_total", 64'(ferr_cnt - f0), 64'd1);
        check_eq("long_valid", 64'(valid_cnt - v0), 64'd0);

        // Reset during byte 5
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int k = 0; k < 5; k++) send_byte(8'h55);
        tr_up();
        send_bits(8'h55, 4);
        rst = 1'b1;
        line_transmission = 1'b0;
        line_clock = 1'b0;
        line_data = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        check_eq("rst_data", data, 64'h0);
        check_eq("rst_valid", {63'h0, valid}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_ferr", {63'h0, frame_error}, 64'h0);
        wait_cyc(10);
        $display("reset mid-word: data=%h busy=%b", data, busy);
        check_eq("rst_no_ferr", 64'(ferr_cnt - f0), 64'd0);
        send_word(64'hDEAD_BEEF_CAFE_F00D);
        check_eq("after_rst_data", data, 64'hDEAD_BEEF_CAFE_F00D);
        check_eq("after_rst_valid", 64'(valid_cnt - v0), 64'd1);
        check_eq("after_rst_ferr", 64'(ferr_cnt - f0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
